// File: rtl/ripple_carry_add_4b_pkg.sv
// Shared constants for the 4-bit ripple-carry adder slice.
package rca_pkg;

  localparam int unsigned RCA_WIDTH = 4;
  localparam logic [RCA_WIDTH-1:0] RCA_RESET_SUM = 4'b0000;

endpackage : rca_pkg

// File: rtl/ripple_carry_add_4b_full_adder_1b.sv
// One-bit full adder stage. Purely combinational; four of these are chained
// in the top module to form the ripple-carry path.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry for one bit position. The propagate term is shared.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule : full_adder_1b

// File: rtl/ripple_carry_add_4b.sv
// Clocked 4-bit ripple-carry adder with scalar bit ports.
// {Cout,S3..S0} = A + B + Cin, registered with one cycle of latency.
// Optional macro RCA_FLAGS_EN adds registered OVF (c4 ^ c3) and ZERO flags.
module ripple_carry_add_4b
  import rca_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic Cin,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
`ifdef RCA_FLAGS_EN
  output logic Cout,
  output logic OVF,
  output logic ZERO
`else
  output logic Cout
`endif
);

  logic [RCA_WIDTH-1:0] op_a;
  logic [RCA_WIDTH-1:0] op_b;
  logic [RCA_WIDTH-1:0] sum_bits;
  logic [RCA_WIDTH:0]   carry;

  logic [RCA_WIDTH-1:0] sum_d;
  logic [RCA_WIDTH-1:0] sum_q;
  logic                 cout_d;
  logic                 cout_q;

  assign op_a     = {A3, A2, A1, A0};
  assign op_b     = {B3, B2, B1, B0};
  assign carry[0] = Cin;

  // Ripple chain: the carry out of each stage feeds the next stage's carry in.
  for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_stage
    full_adder_1b u_fa (
      .a  (op_a[i]),
      .b  (op_b[i]),
      .ci (carry[i]),
      .s  (sum_bits[i]),
      .co (carry[i+1])
    );
  end

  // Next-state values for the result register, taken straight from the chain.
  always_comb begin
    sum_d  = sum_bits;
    cout_d = carry[RCA_WIDTH];
  end

  // Result register; reset clears it immediately and discards any pending add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= RCA_RESET_SUM;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign {S3, S2, S1, S0} = sum_q;
  assign Cout             = cout_q;

`ifdef RCA_FLAGS_EN
  logic ovf_d;
  logic ovf_q;
  logic zero_d;
  logic zero_q;

  // Signed overflow is the carry into the MSB disagreeing with the carry out;
  // ZERO looks only at the sum bits, not at the carry out.
  always_comb begin
    ovf_d  = carry[RCA_WIDTH] ^ carry[RCA_WIDTH-1];
    zero_d = (sum_bits == RCA_RESET_SUM);
  end

  // Flag registers share the latency and reset behaviour of the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign OVF  = ovf_q;
  assign ZERO = zero_q;
`endif

endmodule : ripple_carry_add_4b

// File: tb/tb_ripple_carry_add_4b.sv
// Directed self-checking bench for ripple_carry_add_4b.
// Build with +define+RCA_FLAGS_EN to also check the OVF and ZERO flags.
module tb_ripple_carry_add_4b;

  logic clk;
  logic rst_n;
  logic A3, A2, A1, A0;
  logic B3, B2, B1, B0;
  logic Cin;
  logic S3, S2, S1, S0;
  logic Cout;
`ifdef RCA_FLAGS_EN
  logic OVF;
  logic ZERO;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  ripple_carry_add_4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A3    (A3),
    .A2    (A2),
    .A1    (A1),
    .A0    (A0),
    .B3    (B3),
    .B2    (B2),
    .B1    (B1),
    .B0    (B0),
    .Cin   (Cin),
    .S3    (S3),
    .S2    (S2),
    .S1    (S1),
`ifdef RCA_FLAGS_EN
    .S0    (S0),
    .Cout  (Cout),
    .OVF   (OVF),
    .ZERO  (ZERO)
`else
    .S0    (S0),
    .Cout  (Cout)
`endif
  );

  // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive operand bits from packed values.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic cin);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    Cin = cin;
  endtask

  // Compare registered outputs against hand-computed expectations.
  task automatic checkOutput(input string tag, input logic [3:0] expSum, input logic expCout,
                             input logic expOvf, input logic expZero);
    logic [4:0] observed;
    logic [4:0] expected;
    observed = {Cout, S3, S2, S1, S0};
    expected = {expCout, expSum};
    totalChecks++;
    assert (observed === expected) else begin
      badChecks++;
      $error("[TB] FAIL %s: observed {Cout,S}=%b required=%b", tag, observed, expected);
    end
`ifdef RCA_FLAGS_EN
    totalChecks++;
    assert ({OVF, ZERO} === {expOvf, expZero}) else begin
      badChecks++;
      $error("[TB] FAIL %s flags: observed {OVF,ZERO}=%b%b required=%b%b", tag, OVF, ZERO, expOvf, expZero);
    end
`else
    if (expOvf === 1'bx || expZero === 1'bx) $display("[TB] note: flag expectation undefined for %s", tag);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'd0, 4'd0, 1'b0);

    // Reset held with inputs toggling: outputs must stay zero.
    #1;
    checkOutput("reset_async_start", 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(4'(15 - i), 4'(i + 9), 1'(i));
      @(posedge clk);
      #1;
      checkOutput("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    end

    // Release between edges with 3+4 presented; nothing captured until the edge.
    @(negedge clk);
    applyStimulus(4'b0011, 4'b0100, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_release_pre_edge", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("add_3_4", 4'b0111, 1'b0, 1'b0, 1'b0);

    // New inputs must not appear before the next edge.
    @(negedge clk);
    applyStimulus(4'b0110, 4'b0011, 1'b0);
    #1;
    checkOutput("hold_3_4", 4'b0111, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("add_6_3", 4'b1001, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    applyStimulus(4'b0101, 4'b1000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("add_5_8", 4'b1101, 1'b0, 1'b0, 1'b0);

    // Full ripple through all four stages.
    @(negedge clk);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("add_15_0_c1", 4'b0000, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("add_15_15_c1", 4'b1111, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("add_0_0_c0", 4'b0000, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    applyStimulus(4'b0111, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("add_7_1_ovf", 4'b1000, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    applyStimulus(4'b1001, 4'b0111, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("add_9_7", 4'b0000, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    applyStimulus(4'b1100, 4'b1010, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("add_12_10", 4'b0110, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    applyStimulus(4'b0010, 4'b0101, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("add_2_5_c1", 4'b1000, 1'b0, 1'b1, 1'b0);

    // Mid-operation reset: capture 3+4, then pull reset between edges.
    @(negedge clk);
    applyStimulus(4'b0011, 4'b0100, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("mid_pre_reset", 4'b0111, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_immediate", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("mid_reset_held_edge", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0110, 4'b0011, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_release_pre_edge", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("mid_release_capture", 4'b1001, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule : tb_ripple_carry_add_4b
